x_flashdet: RTL and testbench

X_FLASHDET -- requirements
Module: x_flashdet

---
 rtl/x_flashdet_pkg.sv | 15 +
 rtl/x_sync2.sv | 22 ++
 rtl/x_flashdet.sv | 144 ++++++++++++++
 tb/tb_x_flashdet.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/x_flashdet_pkg.sv
// Shared flash constants: detector FSM encoding alongside the flash generator's states.
// Pure declarations; no timing, no backpressure.
package x_flashdet_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_QUAL  = 3'd1;
  localparam logic [2:0] ST_FLASH = 3'd2;
  localparam logic [2:0] ST_TAIL  = 3'd3;
  localparam logic [2:0] ST_HELD  = 3'd4;

  localparam logic [1:0] FG_OFF = 2'd0;
  localparam logic [1:0] FG_ON  = 2'd1;
  localparam logic [1:0] FG_GAP = 2'd2;

endpackage

// File: rtl/x_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency 2 clocks; no backpressure.
module x_sync2 (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/x_flashdet.sv
// Flash pulse qualifier/length checker with registered strobes and saturating event count.
// Event 2+MINW clocks after din first samples high; no backpressure (strobes are fire-and-forget).
module x_flashdet
  import x_flashdet_pkg::*;
#(
  parameter int MXCNT = 19,
  parameter int MINW  = 4,
  parameter int TAILW = 16,
  parameter int CNTW  = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            din,
  input  logic            clr_cnt,
  output logic            evt,
  output logic            done,
  output logic            err_short,
  output logic            glitch,
  output logic            held,
  output logic            busy,
  output logic [CNTW-1:0] evt_cnt
);

  localparam int TW = $clog2(TAILW + 1);
  localparam logic [MXCNT:0] MINW_C = (MXCNT + 1)'(MINW);
  localparam logic [MXCNT:0] FULL_C = {1'b1, {MXCNT{1'b0}}};
  localparam logic [TW-1:0]  TAIL_C = TW'(TAILW);

  logic            din_s;
  logic [2:0]      state, state_nx;
  logic [MXCNT:0]  wcnt, wcnt_nx;
  logic [TW-1:0]   tcnt, tcnt_nx;
  logic            evt_nx, done_nx, err_nx, glitch_nx;

  x_sync2 u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (din),
    .q       (din_s)
  );

  always_comb begin
    state_nx  = state;
    wcnt_nx   = wcnt;
    tcnt_nx   = tcnt;
    evt_nx    = 1'b0;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    glitch_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        wcnt_nx = '0;
        tcnt_nx = '0;
        if (din_s) state_nx = ST_QUAL;
      end
      ST_QUAL: begin
        if (!din_s) begin
          glitch_nx = 1'b1;
          state_nx  = ST_IDLE;
          wcnt_nx   = '0;
        end else begin
          wcnt_nx = wcnt + 1'b1;
          if (wcnt_nx == MINW_C) begin
            evt_nx   = 1'b1;
            state_nx = ST_FLASH;
          end
        end
      end
      ST_FLASH: begin
        if (!din_s) begin
          err_nx   = 1'b1;
          state_nx = ST_IDLE;
          wcnt_nx  = '0;
        end else begin
          // Counter stops at 2^MXCNT; the MSB alone marks a full-length flash.
          if (wcnt != FULL_C) wcnt_nx = wcnt + 1'b1;
          if (wcnt_nx == FULL_C) begin
            state_nx = ST_TAIL;
            tcnt_nx  = '0;
          end
        end
      end
      ST_TAIL: begin
        if (!din_s) begin
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
          wcnt_nx  = '0;
          tcnt_nx  = '0;
        end else begin
          tcnt_nx = tcnt + 1'b1;
          if (tcnt_nx == TAIL_C) state_nx = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!din_s) begin
          state_nx = ST_IDLE;
          wcnt_nx  = '0;
          tcnt_nx  = '0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        wcnt_nx  = '0;
        tcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      tcnt      <= '0;
      evt       <= 1'b0;
      done      <= 1'b0;
      err_short <= 1'b0;
      glitch    <= 1'b0;
      held      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      tcnt      <= tcnt_nx;
      evt       <= evt_nx;
      done      <= done_nx;
      err_short <= err_nx;
      glitch    <= glitch_nx;
      held      <= (state_nx == ST_HELD);
      busy      <= (state_nx != ST_IDLE);
    end
  end

  // Counts the registered strobe, so a clear seen while evt is high still records that event.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      evt_cnt <= '0;
    end else if (clr_cnt) begin
      evt_cnt <= evt ? CNTW'(1) : '0;
    end else if (evt && (evt_cnt != {CNTW{1'b1}})) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_x_flashdet.sv
// Scoreboard bench for x_flashdet: strobe kinds and cycles are queued at stimulus time.
// A negedge monitor pops and compares every strobe and held edge the DUT produces.
module tb_x_flashdet;

  localparam int MXCNT = 4;
  localparam int MINW  = 4;
  localparam int TAILW = 8;
  localparam int CNTW  = 4;
  localparam int FULL  = 1 << MXCNT;
  localparam int MAXC  = (1 << CNTW) - 1;

  localparam int K_EVT = 0, K_DONE = 1, K_ERR = 2, K_GLITCH = 3, K_HRISE = 4, K_HFALL = 5;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            din = 1'b0;
  logic            clr_cnt = 1'b0;
  logic            evt, done, err_short, glitch, held, busy;
  logic [CNTW-1:0] evt_cnt;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;
  logic prev_held = 1'b0;
  logic [5:0] obs;
  exp_t e;

  x_flashdet #(.MXCNT(MXCNT), .MINW(MINW), .TAILW(TAILW), .CNTW(CNTW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .evt       (evt),
    .done      (done),
    .err_short (err_short),
    .glitch    (glitch),
    .held      (held),
    .busy      (busy),
    .evt_cnt   (evt_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_held = 1'b0;
    end else begin
      obs = {prev_held & ~held, ~prev_held & held, glitch, err_short, done, evt};
      for (int k = 0; k < 6; k++) begin
        if (obs[k]) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL strobe_unexpected: kind %0d at cycle %0d, none expected", k, cyc);
          end else begin
            e = sb.pop_front();
            if (e.kind !== k || e.cyc !== cyc) begin
              n_fail++;
              $display("FAIL strobe_match: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                       k, cyc, e.kind, e.cyc);
            end
          end
        end
      end
      prev_held = held;
    end
  end

  function automatic void push(input int kind, input int c);
    exp_t x;
    x.kind = kind;
    x.cyc  = c;
    sb.push_back(x);
  endfunction

  // Drives one pulse sampled high on edges n..n+len-1 and queues the resulting strobes.
  task automatic pulse(input int len, input bit clr_evt);
    int n;
    @(posedge clock); #1;
    din = 1'b1;
    n = cyc + 1;
    if (len <= MINW) begin
      push(K_GLITCH, n + len + 2);
    end else begin
      push(K_EVT, n + 2 + MINW);
      exp_cnt = clr_evt ? 1 : ((exp_cnt == MAXC) ? MAXC : exp_cnt + 1);
      if (len <= FULL) begin
        push(K_ERR, n + len + 2);
      end else if (len <= FULL + TAILW) begin
        push(K_DONE, n + len + 2);
      end else begin
        push(K_HRISE, n + FULL + TAILW + 2);
        push(K_HFALL, n + len + 2);
      end
    end
    for (int k = 0; k < len + 8; k++) begin
      @(posedge clock); #1;
      if (k == len - 1) din = 1'b0;
      clr_cnt = clr_evt && (cyc == n + 2 + MINW);
    end
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({evt, done, err_short, glitch, held, busy} !== 6'b0 || evt_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got strobes/levels %b cnt %0d, required 000000 cnt 0",
               {evt, done, err_short, glitch, held, busy}, evt_cnt);
    end
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: busy %b, required 0", busy);
    end
  endtask

  task automatic test_end(input string name);
    n_checks++;
    if (evt_cnt !== CNTW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL %s_cnt: evt_cnt %0d, required %0d", name, evt_cnt, exp_cnt);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: %0d expected strobes never seen, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_glitch();
    pulse(2, 1'b0);
    test_end("glitch");
  endtask

  task automatic test_flash();
    pulse(18, 1'b0);
    test_end("flash");
  endtask

  task automatic test_short();
    pulse(10, 1'b0);
    test_end("short");
  endtask

  task automatic test_held();
    pulse(40, 1'b0);
    test_end("held");
    n_checks++;
    if (held !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_release: held %b busy %b, required 0 0", held, busy);
    end
  endtask

  task automatic test_saturate();
    @(posedge clock); #1 clr_cnt = 1'b1;
    @(posedge clock); #1 clr_cnt = 1'b0;
    exp_cnt = 0;
    test_end("clear");
    for (int p = 0; p < 17; p++) pulse(18, 1'b0);
    test_end("saturate");
  endtask

  task automatic test_clr_collision();
    pulse(18, 1'b1);
    test_end("clr_collision");
  endtask

  task automatic test_reset_mid_flash();
    int n;
    @(posedge clock); #1;
    din = 1'b1;
    n = cyc + 1;
    push(K_EVT, n + 2 + MINW);
    repeat (MINW + 6) @(posedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midflash_busy: busy %b, required 1", busy);
    end
    #2;
    sb.delete();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({evt, done, err_short, glitch, held, busy} !== 6'b0 || evt_cnt !== '0) begin
      n_fail++;
      $display("FAIL midflash_reset: got strobes/levels %b cnt %0d, required 000000 cnt 0",
               {evt, done, err_short, glitch, held, busy}, evt_cnt);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    n = cyc + 1;
    exp_cnt = 1;
    push(K_EVT, n + 2 + MINW);
    push(K_DONE, n + 20 + 2);
    for (int k = 0; k < 28; k++) begin
      @(posedge clock); #1;
      if (k == 19) din = 1'b0;
    end
    test_end("post_reset");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_flash();
    test_short();
    test_held();
    test_saturate();
    test_clr_collision();
    test_reset_mid_flash();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
